// File: rtl/remote_rcv.sv
// NEC infrared remote-control receiver.
// Samples the demodulated IR line (idle high, active low) and measures every
// low/high phase in system-clock cycles. Lead, repeat, bit and stop phases
// are classified against timing windows. A 32-bit frame is shifted in LSB
// first. A decoded command is presented on data with a one-cycle data_en
// strobe. A repeat frame raises repeat_en for one cycle.
//
// Handshake: data_en and repeat_en are single-cycle, registered strobes with
// no back-pressure. data is updated only in the same cycle as data_en and is
// held until the next valid frame. The two strobes are mutually exclusive.
//
// state_dbg exposes the FSM state for checkers. IDLE is encoded as 0.
module remote_rcv #(
  parameter int CNT_W    = 19,
  // Divides every timing window. 1 gives the real 50 MHz NEC timing. Larger
  // values give scaled-down timing for simulation.
  parameter int TIME_DIV = 1
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       remote_in,
  output logic       repeat_en,
  output logic       data_en,
  output logic [7:0] data,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LEAD_L   = 3'd1,
    LEAD_H   = 3'd2,
    BIT_L    = 3'd3,
    BIT_H    = 3'd4,
    REP_STOP = 3'd5
  } state_t;

  // Timing windows in clock cycles (20 ns each at TIME_DIV = 1).
  localparam logic [CNT_W-1:0] LEAD_L_MIN = CNT_W'(400000 / TIME_DIV);
  localparam logic [CNT_W-1:0] LEAD_L_MAX = CNT_W'(500000 / TIME_DIV);
  localparam logic [CNT_W-1:0] HEAD_D_MIN = CNT_W'(200000 / TIME_DIV);
  localparam logic [CNT_W-1:0] HEAD_D_MAX = CNT_W'(250000 / TIME_DIV);
  localparam logic [CNT_W-1:0] HEAD_R_MIN = CNT_W'(100000 / TIME_DIV);
  localparam logic [CNT_W-1:0] HEAD_R_MAX = CNT_W'(125000 / TIME_DIV);
  localparam logic [CNT_W-1:0] BIT_L_MIN  = CNT_W'(20000 / TIME_DIV);
  localparam logic [CNT_W-1:0] BIT_L_MAX  = CNT_W'(35000 / TIME_DIV);
  localparam logic [CNT_W-1:0] ZERO_MIN   = CNT_W'(20000 / TIME_DIV);
  localparam logic [CNT_W-1:0] ZERO_MAX   = CNT_W'(35000 / TIME_DIV);
  localparam logic [CNT_W-1:0] ONE_MIN    = CNT_W'(70000 / TIME_DIV);
  localparam logic [CNT_W-1:0] ONE_MAX    = CNT_W'(95000 / TIME_DIV);

  state_t             state;
  state_t             state_nxt;
  logic               sync1;
  logic               sync2;
  logic               prev;
  logic               fall;
  logic               rise;
  logic [CNT_W-1:0]   cnt;
  logic [5:0]         bit_cnt;
  logic [31:0]        sh;
  logic [31:0]        sh_new;
  logic               win_zero;
  logic               win_one;
  logic               cmd_ok;
  logic               clr_frame;
  logic               shift_en;
  logic               data_pulse;
  logic               rep_pulse;

  function automatic logic in_win(input logic [CNT_W-1:0] w,
                                  input logic [CNT_W-1:0] lo,
                                  input logic [CNT_W-1:0] hi);
    return (w >= lo) && (w <= hi);
  endfunction

  assign state_dbg = state;

  // Two-flop synchronizer plus one delayed copy for edge detection; idles high.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= remote_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign fall = prev & ~sync2;
  assign rise = ~prev & sync2;

  // Phase-width counter: restarts on every edge and saturates so that a long
  // idle line cannot wrap around into a window.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt <= '0;
    end else if (fall || rise) begin
      cnt <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Bit classification and the frame word as it would look after this shift.
  // On the 32nd bit, the command check must see the incoming bit.
  assign win_zero = in_win(cnt, ZERO_MIN, ZERO_MAX);
  assign win_one  = in_win(cnt, ONE_MIN, ONE_MAX);
  assign sh_new   = {win_one, sh[31:1]};
  assign cmd_ok   = (sh_new[23:16] == ~sh_new[31:24]);

  // FSM state register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and datapath controls. Every non-idle state falls back to
  // IDLE once the phase outlasts the longest window that state can accept.
  always_comb begin
    state_nxt  = state;
    clr_frame  = 1'b0;
    shift_en   = 1'b0;
    data_pulse = 1'b0;
    rep_pulse  = 1'b0;
    case (state)
      IDLE: begin
        if (fall) state_nxt = LEAD_L;
      end
      LEAD_L: begin
        if (rise) begin
          state_nxt = in_win(cnt, LEAD_L_MIN, LEAD_L_MAX) ? LEAD_H : IDLE;
        end else if (cnt > LEAD_L_MAX) begin
          state_nxt = IDLE;
        end
      end
      LEAD_H: begin
        if (fall) begin
          if (in_win(cnt, HEAD_D_MIN, HEAD_D_MAX)) begin
            state_nxt = BIT_L;
            clr_frame = 1'b1;
          end else if (in_win(cnt, HEAD_R_MIN, HEAD_R_MAX)) begin
            state_nxt = REP_STOP;
          end else begin
            state_nxt = IDLE;
          end
        end else if (cnt > HEAD_D_MAX) begin
          state_nxt = IDLE;
        end
      end
      BIT_L: begin
        if (rise) begin
          state_nxt = in_win(cnt, BIT_L_MIN, BIT_L_MAX) ? BIT_H : IDLE;
        end else if (cnt > BIT_L_MAX) begin
          state_nxt = IDLE;
        end
      end
      BIT_H: begin
        if (fall) begin
          if (win_zero || win_one) begin
            shift_en = 1'b1;
            if (bit_cnt == 6'd31) begin
              // This fall opens the stop burst; the frame is complete.
              state_nxt  = IDLE;
              data_pulse = cmd_ok;
            end else begin
              state_nxt = BIT_L;
            end
          end else begin
            state_nxt = IDLE;
          end
        end else if (cnt > ONE_MAX) begin
          state_nxt = IDLE;
        end
      end
      REP_STOP: begin
        if (rise) begin
          rep_pulse = in_win(cnt, BIT_L_MIN, BIT_L_MAX);
          state_nxt = IDLE;
        end else if (cnt > BIT_L_MAX) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Frame shift register, bit count, held command byte and output strobes.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bit_cnt   <= '0;
      sh        <= '0;
      data      <= 8'h00;
      data_en   <= 1'b0;
      repeat_en <= 1'b0;
    end else begin
      data_en   <= data_pulse;
      repeat_en <= rep_pulse;
      if (clr_frame) begin
        bit_cnt <= '0;
        sh      <= '0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + 1'b1;
        sh      <= sh_new;
      end
      if (data_pulse) begin
        data <= sh_new[23:16];
      end
    end
  end

endmodule

// File: tb/tb_remote_rcv.sv
// Testbench for remote_rcv, run with timing windows scaled down by 1000.
// The bench drives the IR line as a list of timed low/high phases. A
// frame-level model classifies the phases with the NEC timing windows and
// decides which strobe, if any, must follow. A scoreboard process checks the
// strobes, their deadline and the held data byte on every cycle.
module tb_remote_rcv;

  localparam int DIV = 1000;
  // Windows in scaled cycles.
  localparam int LL_LO = 400, LL_HI = 500;
  localparam int HD_LO = 200, HD_HI = 250;
  localparam int HR_LO = 100, HR_HI = 125;
  localparam int BL_LO = 20,  BL_HI = 35;
  localparam int B0_LO = 20,  B0_HI = 35;
  localparam int B1_LO = 70,  B1_HI = 95;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       remote_in;
  logic       repeat_en;
  logic       data_en;
  logic [7:0] data;
  logic [2:0] state_dbg;

  // Expected queue entry: [40] kind (0 data, 1 repeat), [39:32] byte, [31:0] deadline cycle.
  logic [40:0] exp_q[$];
  logic [7:0]  model_data;
  int          n_tests;
  int          n_fail;
  int          cyc;
  int          n_data_seen;
  int          n_rep_seen;
  bit          chk_on;

  remote_rcv #(.CNT_W(19), .TIME_DIV(DIV)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .remote_in (remote_in),
    .repeat_en (repeat_en),
    .data_en   (data_en),
    .data      (data),
    .state_dbg (state_dbg)
  );

  // Clock and cycle counter.
  initial sys_clk = 1'b0;
  always #10 sys_clk = ~sys_clk;
  initial cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Watchdog.
  initial begin
    #(95000 * 20);
    $display("FAIL watchdog: run did not finish, got cycle %0d, required < 95000", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit in_rng(input int w, input int lo, input int hi);
    return (w >= lo) && (w <= hi);
  endfunction

  function automatic logic [31:0] mk_word(input logic [7:0] addr, input logic [7:0] cmd,
                                          input logic [7:0] inv);
    return {inv, cmd, ~addr, addr};
  endfunction

  // Drive one line level for n cycles, starting just after a falling clock edge.
  task automatic hold(input logic lvl, input int n);
    remote_in = lvl;
    repeat (n) @(negedge sys_clk);
  endtask

  // Send a data frame. The model decides, from the phase widths actually sent,
  // whether a command must be reported. bad_bit gives one bit an in-between
  // high width. abort_bit stops the frame partway through that bit's low phase.
  task automatic send_frame(input int ll, input int lh, input logic [31:0] word,
                            input bit jitter, input int bad_bit, input int abort_bit);
    bit          ok;
    logic [31:0] rx;
    int          bl;
    int          bh;
    ok = in_rng(ll, LL_LO, LL_HI) && in_rng(lh, HD_LO, HD_HI);
    rx = '0;
    hold(1'b0, ll);
    hold(1'b1, lh);
    for (int i = 0; i < 32; i++) begin
      if (i == abort_bit) begin
        remote_in = 1'b0;
        repeat (10) @(negedge sys_clk);
        return;
      end
      bl = jitter ? int'($urandom_range(24, 32)) : 28;
      if (i == bad_bit)  bh = 50;
      else if (word[i])  bh = jitter ? int'($urandom_range(76, 90)) : 84;
      else               bh = jitter ? int'($urandom_range(24, 32)) : 28;
      if (!in_rng(bl, BL_LO, BL_HI)) ok = 1'b0;
      if (in_rng(bh, B0_LO, B0_HI))      rx[i] = 1'b0;
      else if (in_rng(bh, B1_LO, B1_HI)) rx[i] = 1'b1;
      else                               ok = 1'b0;
      hold(1'b0, bl);
      hold(1'b1, bh);
    end
    // Stop burst: its falling edge completes the frame.
    if (ok && (rx[23:16] == ~rx[31:24])) exp_q.push_back({1'b0, rx[23:16], 32'(cyc + 4)});
    hold(1'b0, 28);
    hold(1'b1, 150);
  endtask

  // Send a repeat frame: lead low, short lead high, one burst.
  task automatic send_repeat(input int ll, input int lh, input int bl);
    hold(1'b0, ll);
    hold(1'b1, lh);
    hold(1'b0, bl);
    if (in_rng(ll, LL_LO, LL_HI) && in_rng(lh, HR_LO, HR_HI) && in_rng(bl, BL_LO, BL_HI))
      exp_q.push_back({1'b1, 8'h00, 32'(cyc + 4)});
    hold(1'b1, 150);
  endtask

  // Scoreboard: strobes against the expected queue, deadline, and the held byte.
  always @(negedge sys_clk) begin
    logic [40:0] e;
    if (chk_on) begin
      if (data_en || repeat_en) begin
        if (data_en)   n_data_seen++;
        if (repeat_en) n_rep_seen++;
        check("strobe_exclusive", {30'd0, data_en, repeat_en} == 32'd3, 32'd0);
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_strobe: got data_en=%0b repeat_en=%0b, required none", data_en, repeat_en);
        end else begin
          e = exp_q.pop_front();
          check("strobe_kind", {31'd0, repeat_en}, {31'd0, e[40]});
          if (!e[40]) model_data = e[39:32];
        end
      end else if (exp_q.size() > 0 && cyc > int'(exp_q[0][31:0])) begin
        e = exp_q.pop_front();
        n_tests++;
        n_fail++;
        $display("FAIL missed_strobe: got no strobe by cycle %0d, required kind %0d byte 0x%0h", cyc, e[40], e[39:32]);
      end
      check("data_held", data, model_data);
    end
  end

  initial begin
    int          d0, r0;
    logic [7:0]  c;
    logic [7:0]  inv;
    int          kind;
    n_tests = 0;
    n_fail = 0;
    n_data_seen = 0;
    n_rep_seen = 0;
    model_data = 8'h00;
    chk_on = 1'b0;
    remote_in = 1'b1;
    sys_rst_n = 1'b0;

    // 1: reset for 100 ns, then idle line.
    #100;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    chk_on = 1'b1;
    hold(1'b1, 50);
    check("s1_data", data, 8'h00);
    check("s1_data_en", data_en, 0);
    check("s1_repeat_en", repeat_en, 0);
    check("s1_state_idle", state_dbg, 0);

    // 2: nominal frame, address 00, command 0F.
    d0 = n_data_seen; r0 = n_rep_seen;
    send_frame(450, 225, mk_word(8'h00, 8'h0F, 8'hF0), 1'b0, -1, -1);
    check("s2_data", data, 8'h0F);
    check("s2_model", model_data, 8'h0F);
    check("s2_data_pulses", n_data_seen - d0, 1);
    check("s2_rep_pulses", n_rep_seen - r0, 0);

    // 3: repeat frame.
    d0 = n_data_seen; r0 = n_rep_seen;
    send_repeat(450, 112, 28);
    check("s3_rep_pulses", n_rep_seen - r0, 1);
    check("s3_data_pulses", n_data_seen - d0, 0);
    check("s3_data", data, 8'h0F);

    // 4: corrupted inverse.
    d0 = n_data_seen;
    send_frame(450, 225, mk_word(8'h00, 8'h12, 8'h12), 1'b0, -1, -1);
    check("s4_data_pulses", n_data_seen - d0, 0);
    check("s4_data", data, 8'h0F);

    // 5: short lead then a correct frame.
    d0 = n_data_seen; r0 = n_rep_seen;
    send_frame(250, 225, mk_word(8'h00, 8'h5A, 8'hA5), 1'b0, -1, -1);
    check("s5_short_lead_pulses", (n_data_seen - d0) + (n_rep_seen - r0), 0);
    send_frame(450, 225, mk_word(8'h00, 8'h5A, 8'hA5), 1'b0, -1, -1);
    check("s5_data", data, 8'h5A);
    check("s5_model", model_data, 8'h5A);

    // Timeout: lead low, then the line stays high past the longest lead-high.
    hold(1'b0, 450);
    hold(1'b1, 300);
    check("timeout_idle", state_dbg, 0);
    check("timeout_data", data, 8'h5A);

    // 6: reset during bit 10, then a full A5 frame.
    send_frame(450, 225, mk_word(8'h3C, 8'h33, 8'hCC), 1'b0, -1, 10);
    #2;
    sys_rst_n = 1'b0;
    model_data = 8'h00;
    exp_q.delete();
    remote_in = 1'b1;
    #1;
    check("s6_rst_data", data, 8'h00);
    check("s6_rst_data_en", data_en, 0);
    check("s6_rst_repeat_en", repeat_en, 0);
    check("s6_rst_state", state_dbg, 0);
    repeat (5) @(negedge sys_clk);
    #2;
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    hold(1'b1, 100);
    d0 = n_data_seen;
    send_frame(450, 225, mk_word(8'h00, 8'hA5, 8'h5A), 1'b0, -1, -1);
    check("s6_data", data, 8'hA5);
    check("s6_data_pulses", n_data_seen - d0, 1);

    // Randomized frames with jittered timing.
    for (int k = 0; k < 5; k++) begin
      kind = int'($urandom_range(0, 9));
      c = 8'($urandom);
      inv = (kind < 2) ? 8'($urandom) : ~c;
      if (kind == 9) begin
        send_repeat(int'($urandom_range(420, 480)), int'($urandom_range(105, 120)),
                    int'($urandom_range(24, 32)));
      end else begin
        send_frame(int'($urandom_range(420, 480)), int'($urandom_range(210, 240)),
                   mk_word(8'($urandom), c, inv), 1'b1, (kind == 2) ? int'($urandom_range(0, 31)) : -1, -1);
      end
    end

    repeat (20) @(negedge sys_clk);
    check("pending_expectations", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
